// File: rtl/seven_segment_scan.sv
// seven_segment_scan: double-dabble binary-to-BCD converter driving a time-multiplexed seven-segment display
module seven_segment_scan #(
  parameter int WIDTH         = 5,
  parameter int DIGITS        = 2,
  parameter int SCAN_DIV      = 4,
  parameter int BLANK_LEADING = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  number,
  input  logic              load,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DIGITS-1:0] digit_en,
  output logic [6:0]        segments
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t            state_q, state_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_next_q, ovf_next_d;
  logic [BW-1:0]     disp_q, disp_d;
  logic              overflow_q, overflow_d;
  logic              done_q, done_d;
  logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]     scan_idx_q, scan_idx_d;
  logic [DIGITS-1:0] digit_en_q, digit_en_d;
  logic [6:0]        segments_q, segments_d;
  logic [DIGITS-1:0] blank;
  logic              zero_run, blank_sel, wrap;
  logic [3:0]        nib;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b0111111;
      4'd1: seg7 = 7'b0000110;
      4'd2: seg7 = 7'b1011011;
      4'd3: seg7 = 7'b1001111;
      4'd4: seg7 = 7'b1100110;
      4'd5: seg7 = 7'b1101101;
      4'd6: seg7 = 7'b1111101;
      4'd7: seg7 = 7'b0000111;
      4'd8: seg7 = 7'b1111111;
      4'd9: seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction
  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    bcd_adj    = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    case (state_q)
      IDLE: if (load) begin
        state_d    = SHIFT;
        bin_d      = number;
        bcd_d      = '0;
        cnt_d      = '0;
        ovf_next_d = 32'(number) > MAX_VAL;
      end
      SHIFT: begin
        bcd_d = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = COMMIT;
      end
      COMMIT: begin
        state_d    = IDLE;
        disp_d     = ovf_next_q ? '0 : bcd_q;
        overflow_d = ovf_next_q;
        done_d     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // A digit above the ones is blank when it and every digit above it are zero.
  always_comb begin
    zero_run   = 1'b1;
    blank      = '0;
    nib        = '0;
    blank_sel  = 1'b0;
    digit_en_d = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp_q[4*i +: 4] == 4'd0);
      blank[i] = (BLANK_LEADING != 0) && (i > 0) && zero_run;
    end
    for (int i = 0; i < DIGITS; i++) begin
      digit_en_d[i] = scan_idx_q == IW'(i);
      if (scan_idx_q == IW'(i)) begin
        nib       = disp_q[4*i +: 4];
        blank_sel = blank[i];
      end
    end
    wrap       = scan_cnt_q == SW'(SCAN_DIV - 1);
    scan_cnt_d = wrap ? '0 : scan_cnt_q + 1'b1;
    scan_idx_d = wrap ? (scan_idx_q == IW'(DIGITS - 1) ? '0 : scan_idx_q + 1'b1) : scan_idx_q;
    segments_d = overflow_q ? 7'b1000000 : blank_sel ? 7'b0000000 : seg7(nib);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      disp_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      scan_cnt_q <= '0;
      scan_idx_q <= '0;
      digit_en_q <= '0;
      segments_q <= '0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      disp_q     <= disp_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      digit_en_q <= digit_en_d;
      segments_q <= segments_d;
    end
  end
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign digit_en = digit_en_q;
  assign segments = segments_q;
endmodule

// File: tb/tb_seven_segment_scan.sv
// tb_seven_segment_scan: directed checks of conversion handshake, decoding, blanking, overflow and scan timing
module tb_seven_segment_scan;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] number0 = '0;
  logic [7:0] number1 = '0;
  logic [4:0] number2 = '0;
  logic       load0 = 1'b0, load1 = 1'b0, load2 = 1'b0;
  logic       busy0, done0, ovf0, busy1, done1, ovf1, busy2, done2, ovf2;
  logic [1:0] en0, en1, en2;
  logic [6:0] seg0, seg1, seg2;
  int         errors = 0;
  int         checks = 0;
  localparam logic [6:0] SEGT [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                       7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  always #5 clk = ~clk;
  seven_segment_scan u0 (.clk(clk), .reset(reset), .number(number0), .load(load0), .busy(busy0),
    .done(done0), .overflow(ovf0), .digit_en(en0), .segments(seg0));
  seven_segment_scan #(.WIDTH(8)) u1 (.clk(clk), .reset(reset), .number(number1), .load(load1),
    .busy(busy1), .done(done1), .overflow(ovf1), .digit_en(en1), .segments(seg1));
  seven_segment_scan #(.SCAN_DIV(1)) u2 (.clk(clk), .reset(reset), .number(number2), .load(load2),
    .busy(busy2), .done(done2), .overflow(ovf2), .digit_en(en2), .segments(seg2));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [6:0] exp_seg(input int v, input int i);
    int p;
    p = (i == 0) ? 1 : 10;
    if (v > 99) return 7'b1000000;
    if (i > 0 && v < p) return 7'b0000000;
    return SEGT[(v / p) % 10];
  endfunction
  task automatic wait_done(input int which);
    int k;
    for (k = 0; k < 30; k++) begin
      if ((which == 0 ? done0 : done1) == 1'b1) break;
      @(negedge clk);
    end
    if (k == 30) chk("done_timeout", 32'(which == 0 ? done0 : done1), 32'd1);
  endtask
  task automatic conv(input int which, input int n);
    if (which == 0) begin number0 = 5'(n); load0 = 1'b1; end
    else begin number1 = 8'(n); load1 = 1'b1; end
    @(negedge clk);
    load0 = 1'b0;
    load1 = 1'b0;
    wait_done(which);
    @(negedge clk);
  endtask
  task automatic check_digit(input int which, input int i, input int v, input string tag);
    logic [1:0] want;
    int k;
    want = (i == 0) ? 2'b01 : 2'b10;
    for (k = 0; k < 12 && (which == 0 ? en0 : en1) != want; k++) @(negedge clk);
    if (k == 12) chk({tag, "_en"}, 32'(which == 0 ? en0 : en1), 32'(want));
    chk(tag, 32'(which == 0 ? seg0 : seg1), 32'(exp_seg(v, i)));
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_en", 32'(en0), 32'd0);
    chk("rst_seg", 32'(seg0), 32'd0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("scan_en_%0d", k), 32'(en0), k <= 4 ? 32'd1 : 32'd2);
      chk($sformatf("scan_seg_%0d", k), 32'(seg0), k <= 4 ? 32'b0111111 : 32'd0);
      chk($sformatf("fast_en_%0d", k), 32'(en2), (k % 2 == 1) ? 32'd1 : 32'd2);
    end
    number0 = 5'd17;
    load0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      load0 = 1'b0;
      chk($sformatf("l17_busy_%0d", k), 32'(busy0), k <= 6 ? 32'd1 : 32'd0);
      chk($sformatf("l17_done_%0d", k), 32'(done0), k == 7 ? 32'd1 : 32'd0);
    end
    check_digit(0, 0, 17, "l17_ones");
    check_digit(0, 1, 17, "l17_tens");
    for (int v = 0; v < 32; v++) begin
      conv(0, v);
      chk($sformatf("sweep%0d_ovf", v), 32'(ovf0), 32'd0);
      check_digit(0, 0, v, $sformatf("sweep%0d_d0", v));
      check_digit(0, 1, v, $sformatf("sweep%0d_d1", v));
    end
    conv(1, 100);
    chk("w8_100_ovf", 32'(ovf1), 32'd1);
    check_digit(1, 0, 100, "w8_100_d0");
    check_digit(1, 1, 100, "w8_100_d1");
    conv(1, 99);
    chk("w8_99_ovf", 32'(ovf1), 32'd0);
    check_digit(1, 0, 99, "w8_99_d0");
    check_digit(1, 1, 99, "w8_99_d1");
    number0 = 5'd5;
    load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    @(negedge clk);
    number0 = 5'd9;
    load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    number0 = 5'd0;
    cnt = 0;
    for (int k = 0; k < 14; k++) begin
      if (done0) cnt++;
      @(negedge clk);
    end
    chk("ign_done_count", 32'(cnt), 32'd1);
    check_digit(0, 0, 5, "ign_d0");
    check_digit(0, 1, 5, "ign_d1");
    number0 = 5'd5;
    load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    wait_done(0);
    number0 = 5'd9;
    load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    chk("donecyc_busy", 32'(busy0), 32'd1);
    wait_done(0);
    @(negedge clk);
    check_digit(0, 0, 9, "donecyc_d0");
    conv(0, 12);
    check_digit(0, 0, 12, "pre_d0");
    check_digit(0, 1, 12, "pre_d1");
    number0 = 5'd25;
    load0 = 1'b1;
    @(negedge clk);
    load0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(busy0), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy0), 32'd0);
    chk("abort_en", 32'(en0), 32'd0);
    reset = 1'b0;
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done0) cnt++;
    end
    chk("abort_done_count", 32'(cnt), 32'd0);
    chk("abort_busy_after", 32'(busy0), 32'd0);
    chk("abort_ovf", 32'(ovf0), 32'd0);
    check_digit(0, 0, 0, "abort_d0");
    check_digit(0, 1, 0, "abort_d1");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
